gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that exhaustively exercises one two-input gate under test (any `OR_GATE`, `NAND_GATE` or similar with ports `in0`, `in1`, `out`). On `start` it drives the four input vectors 00, 01, 10, 11 onto the gate and waits a programmable settle time for each. It then samples `out`, compares the sample against a 4-bit expected truth table, and reports per-vector mismatches plus an overall pass flag. It sits beside a gate instance in self-check harnesses and on-chip gate BIST wrappers.

## Interface
- `SETTLE`, default 1: number of wait cycles each vector is held before its sampling cycle. Legal range 0..15.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  begin a sweep; accepted only in IDLE.
- `abort`  input  1  cancel a running sweep; return to IDLE.
- `expected`  input  4  truth table; bit `k` is the expected `out` for `{in1,in0}=k`. Latched on the accepted `start`.
- `dut_out`  input  1  output of the gate under test.
- `dut_in0`  output  1  drives gate `in0`; registered.
- `dut_in1`  output  1  drives gate `in1`; registered.
- `busy`  output  1  high in WAIT, SAMPLE and DONE.
- `done`  output  1  one-cycle pulse when a sweep completes.
- `pass`  output  1  1 if the last completed sweep had no mismatches; held until the next accepted `start`.
- `fail_mask`  output  4  bit `k` is set if vector `k` mismatched; held until the next accepted `start`.

## Operation
- Reset: the following hold until the first clock edge after `rst` falls.
  - State = IDLE.
  - `dut_in0`, `dut_in1`, `busy`, `done`, `pass` = 0.
  - `fail_mask` = 0.
  - Internal vector index `vec` = 0 and settle counter `cnt` = 0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE: `{dut_in1,dut_in0}` = 00. On `start` = 1 (and `abort` = 0):
  - latch `expected`;
  - clear `fail_mask` and `pass`;
  - set `vec` = 0 and `cnt` = 0;
  - go to WAIT, or to SAMPLE if `SETTLE` = 0.
- `{dut_in1,dut_in0}` = `vec` in all non-IDLE states except DONE; in DONE they are 00.
- WAIT: `cnt` increments each cycle. When `cnt` = `SETTLE`-1, go to SAMPLE and clear `cnt`.
- SAMPLE: at the closing edge, compare `dut_out` against latched `expected[vec]`. On mismatch, set `fail_mask[vec]`.
  - If `vec` = 3, go to DONE.
  - Otherwise `vec` = `vec`+1 (2-bit, no wrap reached) and go to WAIT (or SAMPLE if `SETTLE` = 0).
- DONE: `done` = 1 for exactly this cycle. `pass` = (final `fail_mask` == 0), including the vector-3 result. Next state is IDLE unconditionally.
- `abort` = 1 in WAIT or SAMPLE:
  - next state is IDLE and `vec` = 0, so `dut_in` = 00;
  - no `done` pulse;
  - `pass` = 0;
  - `fail_mask` keeps the partial results, including no update from the aborted SAMPLE cycle.
- `abort` in IDLE or DONE has no effect.
- `abort` and `start` both high in IDLE: `abort` wins and no sweep starts.
- `start` in WAIT, SAMPLE or DONE is ignored, not queued.
- `rst` asserted mid-sweep returns all outputs to their reset values immediately (asynchronously).

## Timing
- Let E0 be the edge that accepts `start`, and S = `SETTLE`. Cycle n is the cycle following edge En.
- Vector k is on `dut_in` during cycles k(S+1)+1 through (k+1)(S+1).
- `dut_out` for vector k is sampled at edge E((k+1)(S+1)).
- `done` is high in cycle 4(S+1)+1. `pass` is valid from that cycle on.
- `busy` is high in cycles 1 through 4(S+1)+1.
- The earliest next accepted `start` is at edge E(4(S+1)+2).
- Combinational gate depth must settle in under one clock period. S > 0 gives margin for multi-gate DUT chains.

## Test plan
- OR model on `dut_out`, `expected` = 4'b1110, S = 1, `start` at E0:
  - `dut_in` sequence 00,00,01,01,10,10,11,11 in cycles 1–8;
  - `done` in cycle 9;
  - `pass` = 1, `fail_mask` = 0000.
- AND model, `expected` = 4'b1110:
  - `fail_mask` = 0110, `pass` = 0, `done` in cycle 9.
- `abort` raised in cycle 5 (vector 10) with a NOR model and `expected` = 4'b0001:
  - IDLE and `dut_in` = 00 in cycle 6;
  - no `done`;
  - `pass` = 0;
  - `fail_mask` = 0000.
- `start` pulsed again in cycle 4 while busy:
  - ignored;
  - single `done` in cycle 9;
  - a new `start` at E10 re-latches `expected` and clears `fail_mask`.
- `rst` asserted mid-cycle 6:
  - `busy`, `dut_in0`, `dut_in1`, `fail_mask`, `pass` read 0 before the next edge;
  - stays IDLE after release.
- S = 0 with the NAND model, `expected` = 4'b0111:
  - one cycle per vector;
  - `done` in cycle 5;
  - `pass` = 1.

Source files
------------

// File: rtl/gate_sweep_ctrl_if.sv
// Handshake and gate-drive bundle between a sweep controller and its harness.
// The harness owns start/abort/expected and the gate output; the controller owns the rest.
interface gate_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic [3:0] expected;
    logic       dut_out;
    logic       dut_in0;
    logic       dut_in1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;

    modport master (
        output start, abort, expected, dut_out,
        input  dut_in0, dut_in1, busy, done, pass, fail_mask
    );

    modport slave (
        input  start, abort, expected, dut_out,
        output dut_in0, dut_in1, busy, done, pass, fail_mask
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive two-input gate sweeper: drives 00,01,10,11, waits SETTLE cycles per vector,
// samples the gate output and reports a per-vector mismatch mask plus an overall pass flag.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    gate_sweep_ctrl_if.slave  bus
);
    localparam int unsigned VEC_W = 2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       exp_q;
    logic             mismatch_c;
    logic [3:0]       fail_next_c;

    // Mask as it would look after folding in the current sample.
    always_comb begin
        mismatch_c       = bus.dut_out ^ exp_q[vec];
        fail_next_c      = bus.fail_mask;
        fail_next_c[vec] = bus.fail_mask[vec] | mismatch_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            vec           <= '0;
            cnt           <= '0;
            exp_q         <= '0;
            bus.dut_in0   <= 1'b0;
            bus.dut_in1   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.fail_mask <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.dut_in0 <= 1'b0;
                    bus.dut_in1 <= 1'b0;
                    bus.busy    <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        exp_q         <= bus.expected;
                        bus.fail_mask <= '0;
                        bus.pass      <= 1'b0;
                        vec           <= '0;
                        cnt           <= '0;
                        bus.busy      <= 1'b1;
                        state         <= (SETTLE == 0) ? SAMPLE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        state       <= IDLE;
                        vec         <= '0;
                        cnt         <= '0;
                        bus.dut_in0 <= 1'b0;
                        bus.dut_in1 <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.pass    <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= CNT_W'(cnt + 1'b1);
                    end
                end
                SAMPLE: begin
                    if (bus.abort) begin
                        // Aborted sample is discarded; earlier mask bits are kept.
                        state       <= IDLE;
                        vec         <= '0;
                        cnt         <= '0;
                        bus.dut_in0 <= 1'b0;
                        bus.dut_in1 <= 1'b0;
                        bus.busy    <= 1'b0;
                        bus.pass    <= 1'b0;
                    end else begin
                        bus.fail_mask <= fail_next_c;
                        if (vec == VEC_W'(3)) begin
                            state       <= DONE;
                            bus.done    <= 1'b1;
                            bus.pass    <= (fail_next_c == 4'b0000);
                            bus.dut_in0 <= 1'b0;
                            bus.dut_in1 <= 1'b0;
                        end else begin
                            vec         <= VEC_W'(vec + 1'b1);
                            {bus.dut_in1, bus.dut_in0} <= VEC_W'(vec + 1'b1);
                            state       <= (SETTLE == 0) ? SAMPLE : WAIT;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    vec         <= '0;
                    bus.busy    <= 1'b0;
                    bus.dut_in0 <= 1'b0;
                    bus.dut_in1 <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: table of full sweeps plus abort, restart, reset and SETTLE=0 cases.
module tb_gate_sweep_ctrl;
    logic clk;
    logic rst;
    logic [1:0] model_a;
    logic [1:0] model_b;
    int checks;
    int failures;

    gate_sweep_ctrl_if bus_a();
    gate_sweep_ctrl_if bus_b();

    gate_sweep_ctrl #(.SETTLE(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    gate_sweep_ctrl #(.SETTLE(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

    localparam logic [1:0] M_OR = 2'd0, M_AND = 2'd1, M_NOR = 2'd2, M_NAND = 2'd3;

    function automatic logic gate_f(input logic [1:0] m, input logic a1, input logic a0);
        case (m)
            M_OR:    return a1 | a0;
            M_AND:   return a1 & a0;
            M_NOR:   return ~(a1 | a0);
            default: return ~(a1 & a0);
        endcase
    endfunction

    assign bus_a.dut_out = gate_f(model_a, bus_a.dut_in1, bus_a.dut_in0);
    assign bus_b.dut_out = gate_f(model_b, bus_b.dut_in1, bus_b.dut_in0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] model;
        logic [3:0] expected;
        logic [3:0] want_mask;
        logic       want_pass;
    } sweep_t;

    sweep_t tbl[6];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep on DUT A at the next edge (E0); returns in cycle 1.
    task automatic start_a(input logic [1:0] m, input logic [3:0] e);
        model_a        = m;
        bus_a.expected = e;
        bus_a.start    = 1'b1;
        step();
        bus_a.start    = 1'b0;
    endtask

    task automatic full_sweep_a(input sweep_t t);
        start_a(t.model, t.expected);
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("a_vec_c%0d", c), int'({bus_a.dut_in1, bus_a.dut_in0}), (c - 1) / 2);
            chk($sformatf("a_busy_c%0d", c), int'(bus_a.busy), 1);
            chk($sformatf("a_done_c%0d", c), int'(bus_a.done), 0);
            step();
        end
        chk("a_done_c9", int'(bus_a.done), 1);
        chk("a_busy_c9", int'(bus_a.busy), 1);
        chk("a_in_c9", int'({bus_a.dut_in1, bus_a.dut_in0}), 0);
        chk("a_mask_c9", int'(bus_a.fail_mask), int'(t.want_mask));
        chk("a_pass_c9", int'(bus_a.pass), int'(t.want_pass));
        step();
        chk("a_done_c10", int'(bus_a.done), 0);
        chk("a_busy_c10", int'(bus_a.busy), 0);
        chk("a_pass_hold", int'(bus_a.pass), int'(t.want_pass));
    endtask

    int done_cnt;

    initial begin
        checks = 0;
        failures = 0;
        model_a = M_OR;
        model_b = M_OR;
        bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.expected = 4'h0;
        bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.expected = 4'h0;
        rst = 1'b1;

        tbl[0] = '{M_OR,   4'b1110, 4'b0000, 1'b1};
        tbl[1] = '{M_AND,  4'b1110, 4'b0110, 1'b0};
        tbl[2] = '{M_NOR,  4'b0001, 4'b0000, 1'b1};
        tbl[3] = '{M_NAND, 4'b0111, 4'b0000, 1'b1};
        tbl[4] = '{M_OR,   4'b0000, 4'b1110, 1'b0};
        tbl[5] = '{M_NAND, 4'b1110, 4'b1001, 1'b0};

        // Reset state
        step(); step();
        chk("rst_busy", int'(bus_a.busy), 0);
        chk("rst_done", int'(bus_a.done), 0);
        chk("rst_pass", int'(bus_a.pass), 0);
        chk("rst_mask", int'(bus_a.fail_mask), 0);
        chk("rst_in", int'({bus_a.dut_in1, bus_a.dut_in0}), 0);
        chk("rst_b_busy", int'(bus_b.busy), 0);
        rst = 1'b0;
        step();
        chk("idle_busy", int'(bus_a.busy), 0);

        for (int i = 0; i < 6; i++) begin
            full_sweep_a(tbl[i]);
            step();
        end

        // Abort in cycle 5 (vector 10), NOR model; pass from prior sweep must be cleared
        full_sweep_a(tbl[0]);
        start_a(M_NOR, 4'b0001);
        repeat (4) step();
        chk("ab_vec_c5", int'({bus_a.dut_in1, bus_a.dut_in0}), 2);
        bus_a.abort = 1'b1;
        step();
        bus_a.abort = 1'b0;
        chk("ab_busy_c6", int'(bus_a.busy), 0);
        chk("ab_in_c6", int'({bus_a.dut_in1, bus_a.dut_in0}), 0);
        done_cnt = 0;
        for (int c = 6; c <= 12; c++) begin
            if (bus_a.done) done_cnt++;
            step();
        end
        chk("ab_no_done", done_cnt, 0);
        chk("ab_pass", int'(bus_a.pass), 0);
        chk("ab_mask", int'(bus_a.fail_mask), 0);
        chk("ab_busy_after", int'(bus_a.busy), 0);

        // Start and abort together in IDLE: abort wins
        model_a = M_OR;
        bus_a.expected = 4'b1110;
        bus_a.start = 1'b1;
        bus_a.abort = 1'b1;
        step();
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        chk("sa_busy", int'(bus_a.busy), 0);
        step();

        // Second start while busy is ignored; single done in cycle 9; restart at E10
        start_a(M_OR, 4'b1110);
        repeat (3) step();
        bus_a.expected = 4'b0000;
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        done_cnt = 0;
        for (int c = 5; c <= 9; c++) begin
            if (bus_a.done) begin
                done_cnt++;
                chk("rs_done_cycle", c, 9);
            end
            if (c < 9) step();
        end
        chk("rs_one_done", done_cnt, 1);
        chk("rs_mask", int'(bus_a.fail_mask), 0);
        chk("rs_pass", int'(bus_a.pass), 1);
        step();
        chk("rs_idle_c10", int'(bus_a.busy), 0);
        start_a(M_OR, 4'b0000);
        chk("rs_mask_cleared", int'(bus_a.fail_mask), 0);
        chk("rs_pass_cleared", int'(bus_a.pass), 0);
        repeat (8) step();
        chk("rs2_done", int'(bus_a.done), 1);
        chk("rs2_mask", int'(bus_a.fail_mask), 14);
        step(); step();

        // Async reset mid-cycle 6 with a partial mask present
        start_a(M_AND, 4'b1110);
        repeat (5) step();
        chk("ar_mask_pre", int'(bus_a.fail_mask), 2);
        chk("ar_busy_pre", int'(bus_a.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", int'(bus_a.busy), 0);
        chk("ar_in", int'({bus_a.dut_in1, bus_a.dut_in0}), 0);
        chk("ar_mask", int'(bus_a.fail_mask), 0);
        chk("ar_pass", int'(bus_a.pass), 0);
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("ar_idle_busy", int'(bus_a.busy), 0);
        chk("ar_idle_in", int'({bus_a.dut_in1, bus_a.dut_in0}), 0);
        chk("ar_idle_done", int'(bus_a.done), 0);

        // SETTLE = 0: one cycle per vector, done in cycle 5
        for (int t = 0; t < 2; t++) begin
            model_b = (t == 0) ? M_NAND : M_OR;
            bus_b.expected = 4'b0111;
            bus_b.start = 1'b1;
            step();
            bus_b.start = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                chk($sformatf("s0_vec_c%0d", c), int'({bus_b.dut_in1, bus_b.dut_in0}), c - 1);
                chk($sformatf("s0_done_c%0d", c), int'(bus_b.done), 0);
                step();
            end
            chk("s0_done_c5", int'(bus_b.done), 1);
            chk("s0_pass", int'(bus_b.pass), (t == 0) ? 1 : 0);
            chk("s0_mask", int'(bus_b.fail_mask), (t == 0) ? 0 : 9);
            step();
            chk("s0_busy_c6", int'(bus_b.busy), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
